cla_addsub_seq: RTL and testbench

Nibble-serial multi-precision adder/subtractor controller. It accepts two W-bit operands with a start strobe and sequences a single 4-bit carry-lookahead add/sub slice over W/4 cycles. The carry is held in a register between nibbles. It returns a W-bit result with carry-out and signed overflow. It sits between a requester (register file or microsequencer) and the shared 4-bit CLA slice, trading latency for area on wide operands.

---
 rtl/cla_addsub_seq.sv | 93 +++++++++
 tb/tb_cla_addsub_seq.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/cla_addsub_seq.sv
// cla_addsub_seq: nibble-serial W-bit adder/subtractor built around a single 4-bit CLA slice.
// The carry is held in a register between nibbles; the final carry and signed overflow are registered on the last nibble.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] s,
  output logic       c
);
  logic [3:0] bx, g, p;
  logic [4:0] k;
  assign bx = b ^ {4{sub}};
  assign g = a & bx;
  assign p = a ^ bx;
  assign k[0] = cin;
  assign k[1] = g[0] | (p[0] & cin);
  assign k[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign k[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign k[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | (&p & cin);
  assign s = p ^ k[3:0];
  assign c = k[4];
endmodule

module cla_addsub_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] out,
  output logic         cout,
  output logic         v
);
  localparam int N  = W / 4;
  localparam int IW = $clog2(N);
  if (W % 4 != 0 || W < 8) begin : g_bad_width
    $error("cla_addsub_seq: W must be a multiple of 4 and at least 8");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         state, state_nx;
  logic [W-1:0]   x_r, y_r;
  logic           sub_r, carry, c, last, accept;
  logic [IW-1:0]  idx;
  logic [3:0]     xn, yn, s;
  assign xn     = x_r[{idx, 2'b00} +: 4];
  assign yn     = y_r[{idx, 2'b00} +: 4] ^ {4{sub_r}};
  assign last   = idx == IW'(N - 1);
  assign accept = state == IDLE && start;
  assign busy   = state == RUN;
  assign done   = state == DONE;
  // Slice runs in plain add mode; subtraction is folded into yn and the initial carry.
  cla4 u_slice (.a(xn), .b(yn), .cin(carry), .sub(1'b0), .s(s), .c(c));
  always_comb begin
    state_nx = accept ? RUN : (state == RUN && last) ? DONE : (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x_r   <= '0;
      y_r   <= '0;
      sub_r <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      out   <= '0;
      cout  <= 1'b0;
      v     <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        x_r   <= x;
        y_r   <= y;
        sub_r <= sub;
        carry <= sub;
        idx   <= '0;
      end
      if (state == RUN) begin
        out[{idx, 2'b00} +: 4] <= s;
        carry <= c;
        idx   <= last ? idx : idx + 1'b1;
        if (last) begin
          cout <= c;
          v    <= (x_r[W-1] == yn[3]) && (s[3] != x_r[W-1]);
        end
      end
    end
  end
endmodule

// File: tb/tb_cla_addsub_seq.sv
// tb_cla_addsub_seq: directed checks of the 16-bit sequencer plus a sampled operand sweep on an 8-bit instance.
module tb_cla_addsub_seq;
  logic        clk = 0, rst_n = 0, start = 0, sub = 0;
  logic [15:0] x = 0, y = 0, out;
  logic        busy, done, cout, v;
  logic        start8 = 0, sub8 = 0;
  logic [7:0]  x8 = 0, y8 = 0, out8;
  logic        busy8, done8, cout8, v8;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  cla_addsub_seq #(.W(16)) dut (.clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .x(x), .y(y),
    .busy(busy), .done(done), .out(out), .cout(cout), .v(v));
  cla_addsub_seq #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .x(x8), .y(y8),
    .busy(busy8), .done(done8), .out(out8), .cout(cout8), .v(v8));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [15:0] eo, input logic ec, input logic ev);
    int n;
    @(negedge clk);
    x = a; y = b; sub = s; start = 1;
    @(posedge clk); #1;
    start = 0; x = ~a; y = ~b; sub = ~s;
    n = 0;
    while (!done && n < 20) begin
      chk({tag, "_busy"}, busy, 1);
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_out"}, out, eo);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_v"}, v, ev);
    @(posedge clk); #1;
    chk({tag, "_done_fall"}, done, 0);
    chk({tag, "_hold"}, out, eo);
  endtask
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int n, sa, sb, r;
    logic [7:0] eo;
    logic ec, ev;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = s ? sa - sb : sa + sb;
    ev = r > 127 || r < -128;
    ec = s ? (a >= b) : (int'(a) + int'(b) > 255);
    eo = s ? a - b : a + b;
    @(negedge clk);
    x8 = a; y8 = b; sub8 = s; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    n = 0;
    while (!done8 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w8_lat", n, 2);
    chk($sformatf("w8_out_%0h_%0h_%0d", a, b, s), out8, eo);
    chk($sformatf("w8_cout_%0h_%0h_%0d", a, b, s), cout8, ec);
    chk($sformatf("w8_v_%0h_%0h_%0d", a, b, s), v8, ev);
    @(posedge clk); #1;
  endtask
  logic [7:0] vals [20] = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h08, 8'h0F, 8'h10, 8'h55, 8'h7E, 8'h7F,
                            8'h80, 8'h81, 8'hAA, 8'hC8, 8'hF0, 8'hFE, 8'hFF, 8'h33, 8'h99, 8'h6C};
  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", out, 0);
    chk("rst_cout", cout, 0);
    chk("rst_v", v, 0);
    @(negedge clk);
    rst_n = 1;
    op16("add_ffff_1", 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0);
    op16("add_7fff_1", 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1);
    op16("add_1234_4321", 16'h1234, 16'h4321, 0, 16'h5555, 0, 0);
    op16("sub_8000_1", 16'h8000, 16'h0001, 1, 16'h7FFF, 1, 1);
    op16("sub_0_1", 16'h0000, 16'h0001, 1, 16'hFFFF, 0, 0);
    op16("sub_5_5", 16'h0005, 16'h0005, 1, 16'h0000, 1, 0);
    op16("add_8000_8000", 16'h8000, 16'h8000, 0, 16'h0000, 1, 1);
    op16("sub_7fff_ffff", 16'h7FFF, 16'hFFFF, 1, 16'h8000, 0, 1);
    // start held high across a whole operation; the second operand set lands at E6
    @(negedge clk);
    x = 16'h1111; y = 16'h2222; sub = 0; start = 1;
    @(posedge clk); #1;
    chk("hold_busy_e0", busy, 1);
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (e == 2) begin
        x = 16'hF000; y = 16'h1000; sub = 1;
      end
      if (e == 6) start = 0;
      chk($sformatf("hold_done_e%0d", e), done, e == 4 || e == 10);
      chk($sformatf("hold_busy_e%0d", e), busy, e < 4 || (e >= 6 && e < 10));
      if (e == 4) begin
        chk("hold_out_a", out, 16'h3333);
        chk("hold_cout_a", cout, 0);
        chk("hold_v_a", v, 0);
      end
      if (e == 10) begin
        chk("hold_out_b", out, 16'hE000);
        chk("hold_cout_b", cout, 1);
        chk("hold_v_b", v, 0);
      end
    end
    // asynchronous reset in the middle of RUN
    @(negedge clk);
    x = 16'h00FF; y = 16'h0000; sub = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_partial", out[7:0], 8'hFF);
    chk("midrst_busy_pre", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_out", out, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_v", v, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_done", done, 0);
    end
    op16("post_rst", 16'hABCD, 16'h1111, 1, 16'h9ABC, 1, 0);
    for (int i = 0; i < 20; i++)
      for (int j = 0; j < 20; j++)
        for (int s = 0; s < 2; s++)
          op8(vals[i], vals[j], s[0]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
